// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants used by the write-back arbiter,
// the register file and decode.
package regfile_wb_arbiter_pkg;

  // Register address and data widths of the architectural register file.
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  // Register 0 is hard-wired to zero; writes to it are discarded.
  localparam logic [RF_AW-1:0] ZERO_REG = '0;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin priority picker. Searches upward from ptr,
// wrapping modulo NREQ, and returns the first set request as a one-hot
// grant plus its encoded index. Reusable for any shared-resource arbiter.
module regfile_wb_arbiter_rr_pick
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Requests at or above the pointer; these win over the wrapped-around ones.
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] search;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      localparam logic [PW-1:0] GI = PW'(gi);
      assign masked[gi] = req[gi] & (GI >= ptr);
    end
  endgenerate

  // Fall back to the full vector when nothing sits at or above the pointer,
  // which is exactly the wrap-around case.
  assign search = (|masked) ? masked : req;
  assign any    = |req;

  // Lowest set bit of the selected search vector.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (search[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = PW'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares the register file's single write port among
// NREQ requesters with round-robin priority and a valid/ready handshake.
// The write is registered one cycle after the grant; writes to register 0
// are accepted but never reach the register file.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [DW-1:0]    wdata,
  output logic             wb_busy
);

  localparam int PW = idx_width(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   ptr_next;
  logic            we_reg;
  logic            we_next;
  logic [AW-1:0]   waddr_reg;
  logic [AW-1:0]   waddr_next;
  logic [DW-1:0]   wdata_reg;
  logic [DW-1:0]   wdata_next;

  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic            blocked;
  logic            fire;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Per-requester slices of the flat address/data buses.
  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  regfile_wb_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Reset and hold both suppress every grant in the current cycle.
  assign blocked   = rst | hold;
  assign req_ready = blocked ? '0 : pick_grant;
  assign fire      = pick_any & ~blocked;
  assign wb_busy   = (|req_valid) & ~(|(req_valid & req_ready));

  // One-hot AND-OR mux of the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr = sel_addr | addr_arr[i];
        sel_data = sel_data | data_arr[i];
      end
    end
  end

  // Next pointer, write strobe and write payload; register-0 writes are
  // consumed without asserting we, and the payload holds when nothing writes.
  always_comb begin
    ptr_next   = ptr_reg;
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    if (fire) begin
      ptr_next = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
      if (sel_addr != AW'(ZERO_REG)) begin
        we_next    = 1'b1;
        waddr_next = sel_addr;
        wdata_next = sel_data;
      end
    end
  end

  // Pointer and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign we    = we_reg;
  assign waddr = waddr_reg;
  assign wdata = wdata_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32).
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later
// (combinational) or 1ns after the following edge (registered).
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic               wb_busy;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .wb_busy   (wb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic chk_write(input string tag, input logic e_we, input logic [AW-1:0] e_addr,
                           input logic [DW-1:0] e_data);
    chk({tag, "_we"}, 64'(we), 64'(e_we));
    chk({tag, "_waddr"}, 64'(waddr), 64'(e_addr));
    chk({tag, "_wdata"}, 64'(wdata), 64'(e_data));
    $display("write %s: we=%0d waddr=%0d wdata=%08h", tag, we, waddr, wdata);
  endtask

  initial begin
    // Reset held two cycles with every requester pending.
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    set_req(0, 5'd1, 32'h0000_00A0);
    set_req(1, 5'd2, 32'h0000_00A1);
    set_req(2, 5'd3, 32'h0000_00A2);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", 64'(req_ready), 64'(3'b000));
      chk("rst_busy", 64'(wb_busy), 64'd1);
      chk_write("rst", 1'b0, 5'd0, 32'd0);
    end
    rst = 1'b0;
    #1;

    // Round robin with all three valid: grants 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      chk("rr_busy", 64'(wb_busy), 64'd0);
      $display("grant rr k=%0d req_ready=%03b", k, req_ready);
      tick();
      chk_write("rr", 1'b1, 5'((k % 3) + 1), 32'h0000_00A0 + 32'(k % 3));
    end

    // Single requester 1; ptr then sits at 2.
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("single_ready", 64'(req_ready), 64'(3'b010));
    tick();
    chk_write("single", 1'b1, 5'd5, 32'hDEAD_BEEF);
    // All valid: the pointer at 2 must select requester 2, then wrap to 0.
    req_valid = 3'b111;
    #1;
    chk("ptr2_ready", 64'(req_ready), 64'(3'b100));
    tick();
    chk_write("ptr2", 1'b1, 5'd3, 32'h0000_00A2);

    // Register 0 write is consumed; payload holds.
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h1234_5678);
    #1;
    chk("r0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk_write("r0", 1'b0, 5'd3, 32'h0000_00A2);
    req_valid = 3'b100;
    set_req(2, 5'd7, 32'h0000_0001);
    #1;
    chk("r7_ready", 64'(req_ready), 64'(3'b100));
    tick();
    chk_write("r7", 1'b1, 5'd7, 32'h0000_0001);

    // Move ptr to 2 via a grant to requester 1.
    req_valid = 3'b010;
    set_req(1, 5'd4, 32'h0000_0044);
    #1;
    chk("pre_hold_ready", 64'(req_ready), 64'(3'b010));
    tick();
    chk_write("pre_hold", 1'b1, 5'd4, 32'h0000_0044);

    // Hold for 3 cycles with requesters 0 and 2 pending.
    req_valid = 3'b101;
    set_req(0, 5'd9, 32'h0000_0099);
    set_req(2, 5'd7, 32'h0000_0022);
    hold      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_ready", 64'(req_ready), 64'(3'b000));
      chk("hold_busy", 64'(wb_busy), 64'd1);
      tick();
      chk_write("hold", 1'b0, 5'd4, 32'h0000_0044);
    end
    hold = 1'b0;
    #1;
    chk("unhold_ready", 64'(req_ready), 64'(3'b100));
    chk("unhold_busy", 64'(wb_busy), 64'd0);
    tick();
    chk_write("unhold", 1'b1, 5'd7, 32'h0000_0022);

    // Reset mid-stream: ptr at 0, stream two grants then pulse rst.
    req_valid = 3'b111;
    set_req(0, 5'd10, 32'h0000_0010);
    set_req(1, 5'd11, 32'h0000_0011);
    set_req(2, 5'd12, 32'h0000_0012);
    #1;
    chk("ms_ready0", 64'(req_ready), 64'(3'b001));
    tick();
    chk_write("ms0", 1'b1, 5'd10, 32'h0000_0010);
    chk("ms_ready1", 64'(req_ready), 64'(3'b010));
    rst = 1'b1;
    #1;
    chk("ms_rst_ready", 64'(req_ready), 64'(3'b000));
    chk("ms_rst_busy", 64'(wb_busy), 64'd1);
    tick();
    chk_write("ms_rst", 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;
    chk("ms_after_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk_write("ms_after", 1'b1, 5'd10, 32'h0000_0010);

    req_valid = 3'b000;
    #1;
    chk("idle_busy", 64'(wb_busy), 64'd0);
    chk("idle_ready", 64'(req_ready), 64'(3'b000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
